instr_encoder: RTL and testbench

- Assembler-side counterpart of the control decoder: accepts symbolic instruction requests and emits 32-bit MIPS instruction words using the same opcode/funct encodings the decoder consumes.
- Writes the words sequentially into word-addressed instruction memory (PC+1 addressing) so that test and boot programs can be built in hardware.
- Expands the LI pseudo-instruction into one or two real instructions through a small state machine.

---
 rtl/instr_enc_pkg.sv | 66 ++++++
 rtl/instr_word_fmt.sv | 38 +++
 rtl/instr_encoder.sv | 251 +++++++++++++++++++++++++
 tb/tb_instr_encoder.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_enc_pkg.sv
// Shared definitions for the instruction encoder.
//   op_t      : symbolic operation codes accepted on req_op
//   OPC_*     : 6-bit MIPS primary opcodes (same values the control decoder consumes)
//   FUNCT_*   : 6-bit SPECIAL/SPECIAL2 function codes
//   *_LSB     : bit positions of the instruction fields
//   fmt_t     : word layout selector for instr_word_fmt
//   state_t   : emission FSM states
// Optional feature macro: INSTR_ENC_MUL_EN (OP_MUL is always enumerated, but is
// only legal when the macro is defined).
package instr_enc_pkg;

    typedef enum logic [4:0] {
        OP_ADD  = 5'd0,  OP_ADDU = 5'd1,  OP_SUB  = 5'd2,  OP_AND  = 5'd3,
        OP_OR   = 5'd4,  OP_XOR  = 5'd5,  OP_NOR  = 5'd6,  OP_SLT  = 5'd7,
        OP_JR   = 5'd8,  OP_JALR = 5'd9,  OP_ADDI = 5'd10, OP_ANDI = 5'd11,
        OP_ORI  = 5'd12, OP_XORI = 5'd13, OP_LW   = 5'd14, OP_SW   = 5'd15,
        OP_BEQ  = 5'd16, OP_LUI  = 5'd17, OP_J    = 5'd18, OP_JAL  = 5'd19,
        OP_LI   = 5'd20, OP_MUL  = 5'd21
    } op_t;

    localparam logic [5:0] OPC_SPECIAL  = 6'b000000;
    localparam logic [5:0] OPC_SPECIAL2 = 6'b011100;
    localparam logic [5:0] OPC_J        = 6'b000010;
    localparam logic [5:0] OPC_JAL      = 6'b000011;
    localparam logic [5:0] OPC_BEQ      = 6'b000100;
    localparam logic [5:0] OPC_ADDI     = 6'b001000;
    localparam logic [5:0] OPC_ANDI     = 6'b001100;
    localparam logic [5:0] OPC_ORI      = 6'b001101;
    localparam logic [5:0] OPC_XORI     = 6'b001110;
    localparam logic [5:0] OPC_LUI      = 6'b001111;
    localparam logic [5:0] OPC_LW       = 6'b100011;
    localparam logic [5:0] OPC_SW       = 6'b101011;

    localparam logic [5:0] FUNCT_JR     = 6'b001000;
    localparam logic [5:0] FUNCT_JALR   = 6'b001001;
    localparam logic [5:0] FUNCT_ADD    = 6'b100000;
    localparam logic [5:0] FUNCT_ADDU   = 6'b100001;
    localparam logic [5:0] FUNCT_SUB    = 6'b100010;
    localparam logic [5:0] FUNCT_AND    = 6'b100100;
    localparam logic [5:0] FUNCT_OR     = 6'b100101;
    localparam logic [5:0] FUNCT_XOR    = 6'b100110;
    localparam logic [5:0] FUNCT_NOR    = 6'b100111;
    localparam logic [5:0] FUNCT_SLT    = 6'b101010;
    localparam logic [5:0] FUNCT_MUL    = 6'b000010;

    localparam int OPC_LSB = 26;
    localparam int RS_LSB  = 21;
    localparam int RT_LSB  = 16;
    localparam int RD_LSB  = 11;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd31;

    typedef enum logic [1:0] {
        FMT_R = 2'd0,
        FMT_I = 2'd1,
        FMT_J = 2'd2
    } fmt_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EMIT1 = 2'd1,
        ST_EMIT2 = 2'd2
    } state_t;

endpackage

// File: rtl/instr_word_fmt.sv
// Combinational field packer: builds a 32-bit MIPS word from its fields.
//   fmt    in  2   layout select (FMT_R / FMT_I / FMT_J)
//   opcode in  6   primary opcode
//   rs,rt,rd in 5  register fields (rd only used by R layout)
//   funct  in  6   function code (R layout)
//   imm    in  16  immediate (I layout)
//   target in  26  jump target (J layout)
//   word   out 32  packed instruction; shamt is always zero
module instr_word_fmt
    import instr_enc_pkg::*;
(
    input  logic [1:0]  fmt,
    input  logic [5:0]  opcode,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [5:0]  funct,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word
);

    logic [31:0] opc_f;

    assign opc_f = 32'(opcode) << OPC_LSB;

    always_comb begin
        word = '0;
        case (fmt)
            FMT_R:   word = opc_f | (32'(rs) << RS_LSB) | (32'(rt) << RT_LSB)
                          | (32'(rd) << RD_LSB) | 32'(funct);
            FMT_I:   word = opc_f | (32'(rs) << RS_LSB) | (32'(rt) << RT_LSB) | 32'(imm);
            FMT_J:   word = opc_f | 32'(target);
            default: word = '0;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: turns symbolic requests into 32-bit MIPS words and
// writes them sequentially into word-addressed instruction memory. The LI
// pseudo-op expands into ADDI, LUI, or LUI+ORI.
//   clk, rst          clock, asynchronous active-high reset
//   start, base_addr  restart program at base_addr (clears count/full/err)
//   req_valid/ready   request handshake
//   req_op            operation (op_t), req_rd/rs/rt register fields
//   req_imm           immediate / offset / jump target
//   mem_we/addr/wdata instruction-memory write port (registered)
//   word_count        words written since start
//   full              the last memory address has been written
//   err               sticky: illegal op or truncated LI
// Optional feature macro: INSTR_ENC_MUL_EN enables the SPECIAL2 MUL encoding.
module instr_encoder
    import instr_enc_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [4:0]        req_op,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_rs,
    input  logic [4:0]        req_rt,
    input  logic [31:0]       req_imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   word_count,
    output logic              full,
    output logic              err
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [ADDR_W-1:0] PTR_ONE   = 1;
    localparam logic [ADDR_W:0]   CNT_ONE   = 1;

    state_t state, state_nx;

    logic [ADDR_W-1:0] ptr;
    logic              accept;
    logic              wr_next;   // a word is registered onto the write port this edge
    logic              set_err;

    // Second-word context for LI, captured on accept.
    logic              li_two;
    logic [4:0]        li_rt;
    logic [15:0]       li_lo;

    // Request decode
    logic              dec_legal, dec_two, imm_fits16;
    logic [1:0]        dec_fmt;
    logic [5:0]        dec_opc, dec_funct;
    logic [4:0]        dec_rs, dec_rt, dec_rd;
    logic [15:0]       dec_imm;

    // Formatter inputs / output
    logic [1:0]        f_fmt;
    logic [5:0]        f_opc, f_funct;
    logic [4:0]        f_rs, f_rt, f_rd;
    logic [15:0]       f_imm;
    logic [31:0]       f_word;

    assign req_ready  = (state == ST_IDLE) & ~full & ~start;
    assign accept     = req_valid & req_ready;
    assign imm_fits16 = (req_imm[31:15] == '0) || (req_imm[31:15] == '1);

    always_comb begin
        dec_legal = 1'b0;
        dec_two   = 1'b0;
        dec_fmt   = FMT_R;
        dec_opc   = OPC_SPECIAL;
        dec_funct = '0;
        dec_rs    = req_rs;
        dec_rt    = req_rt;
        dec_rd    = req_rd;
        dec_imm   = req_imm[15:0];
        case (req_op)
            OP_ADD:  begin dec_legal = 1'b1; dec_funct = FUNCT_ADD;  end
            OP_ADDU: begin dec_legal = 1'b1; dec_funct = FUNCT_ADDU; end
            OP_SUB:  begin dec_legal = 1'b1; dec_funct = FUNCT_SUB;  end
            OP_AND:  begin dec_legal = 1'b1; dec_funct = FUNCT_AND;  end
            OP_OR:   begin dec_legal = 1'b1; dec_funct = FUNCT_OR;   end
            OP_XOR:  begin dec_legal = 1'b1; dec_funct = FUNCT_XOR;  end
            OP_NOR:  begin dec_legal = 1'b1; dec_funct = FUNCT_NOR;  end
            OP_SLT:  begin dec_legal = 1'b1; dec_funct = FUNCT_SLT;  end
            OP_JR: begin
                dec_legal = 1'b1;
                dec_funct = FUNCT_JR;
                dec_rt    = REG_ZERO;
                dec_rd    = REG_ZERO;
            end
            OP_JALR: begin
                // Link register defaults to $ra when none is named.
                dec_legal = 1'b1;
                dec_funct = FUNCT_JALR;
                dec_rt    = REG_ZERO;
                dec_rd    = (req_rd == REG_ZERO) ? REG_RA : req_rd;
            end
            OP_ADDI: begin dec_legal = 1'b1; dec_fmt = FMT_I; dec_opc = OPC_ADDI; end
            OP_ANDI: begin dec_legal = 1'b1; dec_fmt = FMT_I; dec_opc = OPC_ANDI; end
            OP_ORI:  begin dec_legal = 1'b1; dec_fmt = FMT_I; dec_opc = OPC_ORI;  end
            OP_XORI: begin dec_legal = 1'b1; dec_fmt = FMT_I; dec_opc = OPC_XORI; end
            OP_LW:   begin dec_legal = 1'b1; dec_fmt = FMT_I; dec_opc = OPC_LW;   end
            OP_SW:   begin dec_legal = 1'b1; dec_fmt = FMT_I; dec_opc = OPC_SW;   end
            OP_BEQ:  begin dec_legal = 1'b1; dec_fmt = FMT_I; dec_opc = OPC_BEQ;  end
            OP_LUI: begin
                dec_legal = 1'b1;
                dec_fmt   = FMT_I;
                dec_opc   = OPC_LUI;
                dec_rs    = REG_ZERO;
            end
            OP_J:    begin dec_legal = 1'b1; dec_fmt = FMT_J; dec_opc = OPC_J;   end
            OP_JAL:  begin dec_legal = 1'b1; dec_fmt = FMT_J; dec_opc = OPC_JAL; end
            OP_LI: begin
                // Short form ADDI rt,$0,imm when it sign-extends back; else LUI
                // first and an ORI only if the low half carries bits.
                dec_legal = 1'b1;
                dec_fmt   = FMT_I;
                dec_rs    = REG_ZERO;
                if (imm_fits16) begin
                    dec_opc = OPC_ADDI;
                end else begin
                    dec_opc = OPC_LUI;
                    dec_imm = req_imm[31:16];
                    dec_two = (req_imm[15:0] != 16'h0);
                end
            end
`ifdef INSTR_ENC_MUL_EN
            OP_MUL:  begin dec_legal = 1'b1; dec_opc = OPC_SPECIAL2; dec_funct = FUNCT_MUL; end
`endif
            default: ;
        endcase
    end

    // The single formatter serves the request decode in IDLE and the
    // ORI rt,rt,lo follow-up while in EMIT1.
    always_comb begin
        if (state == ST_EMIT1) begin
            f_fmt   = FMT_I;
            f_opc   = OPC_ORI;
            f_funct = '0;
            f_rs    = li_rt;
            f_rt    = li_rt;
            f_rd    = REG_ZERO;
            f_imm   = li_lo;
        end else begin
            f_fmt   = dec_fmt;
            f_opc   = dec_opc;
            f_funct = dec_funct;
            f_rs    = dec_rs;
            f_rt    = dec_rt;
            f_rd    = dec_rd;
            f_imm   = dec_imm;
        end
    end

    instr_word_fmt u_fmt (
        .fmt    (f_fmt),
        .opcode (f_opc),
        .rs     (f_rs),
        .rt     (f_rt),
        .rd     (f_rd),
        .funct  (f_funct),
        .imm    (f_imm),
        .target (req_imm[25:0]),
        .word   (f_word)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    // Next state. The LI follow-up is skipped when the first word filled
    // the last slot (full is already set by then).
    always_comb begin
        state_nx = state;
        if (start) begin
            state_nx = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (accept && dec_legal) state_nx = ST_EMIT1;
                ST_EMIT1: state_nx = (li_two && !full) ? ST_EMIT2 : ST_IDLE;
                ST_EMIT2: state_nx = ST_IDLE;
                default:  state_nx = ST_IDLE;
            endcase
        end
    end

    // Outputs: the write port is registered, so the word for the next
    // state is launched from the current one.
    always_comb begin
        wr_next = 1'b0;
        set_err = 1'b0;
        if (!start) begin
            case (state)
                ST_IDLE: if (accept) begin
                    wr_next = dec_legal;
                    set_err = !dec_legal || (dec_two && ptr == LAST_ADDR);
                end
                ST_EMIT1: wr_next = li_two && !full;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            word_count <= '0;
            full       <= 1'b0;
            err        <= 1'b0;
            ptr        <= '0;
            li_two     <= 1'b0;
            li_rt      <= '0;
            li_lo      <= '0;
        end else if (start) begin
            mem_we     <= 1'b0;
            word_count <= '0;
            full       <= 1'b0;
            err        <= 1'b0;
            ptr        <= base_addr;
            li_two     <= 1'b0;
        end else begin
            mem_we <= wr_next;
            if (set_err) err <= 1'b1;
            if (wr_next) begin
                mem_addr   <= ptr;
                mem_wdata  <= f_word;
                word_count <= word_count + CNT_ONE;
                // Pointer parks on the last address; full blocks further requests.
                if (ptr == LAST_ADDR) full <= 1'b1;
                else                  ptr  <= ptr + PTR_ONE;
            end
            if (accept) begin
                li_two <= dec_two;
                li_rt  <= req_rt;
                li_lo  <= req_imm[15:0];
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;
    import instr_enc_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  base_addr;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_op, req_rd, req_rs, req_rt;
    logic [31:0] req_imm;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [8:0]  word_count;
    logic        full;
    logic        err;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int m_ptr, m_cnt;
    bit m_full, m_err;

    // Write monitor
    logic [7:0]  wq_addr[$];
    logic [31:0] wq_data[$];

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_rd(req_rd), .req_rs(req_rs), .req_rt(req_rt), .req_imm(req_imm),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .word_count(word_count), .full(full), .err(err)
    );

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wq_addr.push_back(mem_addr);
            wq_data.push_back(mem_wdata);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] qd(input int i);
        return (i < wq_data.size()) ? wq_data[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] qa(input int i);
        return (i < wq_addr.size()) ? 32'(wq_addr[i]) : 32'hDEAD_BEEF;
    endfunction

    // MIPS word layouts as plain arithmetic on field values.
    function automatic logic [31:0] rw(input longint opc, rs, rt, rd, f);
        return 32'(opc * 64'd67108864 + rs * 64'd2097152 + rt * 64'd65536 + rd * 64'd2048 + f);
    endfunction
    function automatic logic [31:0] iw(input longint opc, rs, rt, imm);
        return 32'(opc * 64'd67108864 + rs * 64'd2097152 + rt * 64'd65536 + (imm % 65536));
    endfunction
    function automatic logic [31:0] jw(input longint opc, tgt);
        return 32'(opc * 64'd67108864 + (tgt % 67108864));
    endfunction

    // Expected words for one request; n=0 means illegal.
    function automatic void model_enc(input logic [4:0] op, rd, rs, rt, input logic [31:0] imm,
                                      output int n, output logic [31:0] w0, output logic [31:0] w1);
        longint s, u, hi, lo;
        s  = longint'($signed(imm));
        u  = longint'(imm);
        hi = u / 65536;
        lo = u % 65536;
        n = 1; w0 = '0; w1 = '0;
        case (op)
            OP_ADD:  w0 = rw(0, rs, rt, rd, 32);
            OP_ADDU: w0 = rw(0, rs, rt, rd, 33);
            OP_SUB:  w0 = rw(0, rs, rt, rd, 34);
            OP_AND:  w0 = rw(0, rs, rt, rd, 36);
            OP_OR:   w0 = rw(0, rs, rt, rd, 37);
            OP_XOR:  w0 = rw(0, rs, rt, rd, 38);
            OP_NOR:  w0 = rw(0, rs, rt, rd, 39);
            OP_SLT:  w0 = rw(0, rs, rt, rd, 42);
            OP_JR:   w0 = rw(0, rs, 0, 0, 8);
            OP_JALR: w0 = rw(0, rs, 0, (rd == 0) ? 31 : rd, 9);
            OP_ADDI: w0 = iw(8, rs, rt, lo);
            OP_ANDI: w0 = iw(12, rs, rt, lo);
            OP_ORI:  w0 = iw(13, rs, rt, lo);
            OP_XORI: w0 = iw(14, rs, rt, lo);
            OP_LW:   w0 = iw(35, rs, rt, lo);
            OP_SW:   w0 = iw(43, rs, rt, lo);
            OP_BEQ:  w0 = iw(4, rs, rt, lo);
            OP_LUI:  w0 = iw(15, 0, rt, lo);
            OP_J:    w0 = jw(2, u);
            OP_JAL:  w0 = jw(3, u);
            OP_LI: begin
                if (s >= -32768 && s <= 32767) w0 = iw(8, 0, rt, lo);
                else begin
                    w0 = iw(15, 0, rt, hi);
                    if (lo != 0) begin n = 2; w1 = iw(13, rt, rt, lo); end
                end
            end
`ifdef INSTR_ENC_MUL_EN
            OP_MUL:  w0 = rw(28, rs, rt, rd, 2);
`endif
            default: n = 0;
        endcase
    endfunction

    task automatic do_start(input logic [7:0] b);
        @(negedge clk);
        start = 1'b1; base_addr = b;
        #1 chk("ready_during_start", 32'(req_ready), 0);
        @(posedge clk); #1;
        start = 1'b0;
        m_ptr = b; m_cnt = 0; m_full = 0; m_err = 0;
        chk("start_count", 32'(word_count), 0);
        chk("start_full", 32'(full), 0);
        chk("start_err", 32'(err), 0);
    endtask

    task automatic do_req(input logic [4:0] op, rd, rs, rt, input logic [31:0] imm);
        int n, nw;
        logic [31:0] w[2];
        int ea[2];
        bit acc;
        model_enc(op, rd, rs, rt, imm, n, w[0], w[1]);
        wq_addr.delete(); wq_data.delete();
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_rd = rd; req_rs = rs; req_rt = rt; req_imm = imm;
        acc = 0;
        for (int k = 0; k < 4 && !acc; k++) begin
            if (req_ready === 1'b1) begin @(posedge clk); #1; acc = 1; end
            else @(negedge clk);
        end
        req_valid = 1'b0;
        chk("accepted", 32'(acc), 32'(!m_full));
        if (acc) begin
            nw = 0;
            if (n == 0) m_err = 1;
            for (int i = 0; i < n; i++) begin
                if (m_full) begin m_err = 1; break; end
                ea[i] = m_ptr; nw++; m_cnt++;
                if (m_ptr == 255) m_full = 1; else m_ptr++;
            end
            for (int c = 0; c < 3; c++) begin
                chk($sformatf("mem_we_c%0d", c), 32'(mem_we), 32'(c < nw));
                chk($sformatf("ready_c%0d", c), 32'(req_ready), 32'((c >= nw) && !m_full));
                if (c < 2) begin @(posedge clk); #1; end
            end
            chk("nwrites", 32'(wq_data.size()), 32'(nw));
            for (int i = 0; i < nw; i++) begin
                chk($sformatf("addr%0d", i), qa(i), 32'(ea[i]));
                chk($sformatf("data%0d_op%0d", i, op), qd(i), w[i]);
            end
            chk("word_count", 32'(word_count), 32'(m_cnt));
            chk("full", 32'(full), 32'(m_full));
            chk("err", 32'(err), 32'(m_err));
        end
    endtask

    // Accept a request without waiting out its emission (abort scenarios).
    task automatic accept_only(input logic [4:0] op, rt, input logic [31:0] imm);
        wq_addr.delete(); wq_data.delete();
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_rd = 0; req_rs = 0; req_rt = rt; req_imm = imm;
        chk("abort_ready", 32'(req_ready), 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    function automatic logic [31:0] rand_imm();
        logic [31:0] v;
        logic [31:0] edges[4];
        edges[0] = 32'h0000_8000; edges[1] = 32'hFFFF_7FFF;
        edges[2] = 32'h0000_7FFF; edges[3] = 32'hFFFF_8000;
        v = $urandom;
        case ($urandom_range(0, 3))
            0: v = {{16{v[15]}}, v[15:0]};
            1: v = {v[31:16], 16'h0};
            2: ;
            default: v = edges[$urandom_range(0, 3)];
        endcase
        return v;
    endfunction

    initial begin
        rst = 1'b1; start = 1'b0; base_addr = '0; req_valid = 1'b0;
        req_op = '0; req_rd = '0; req_rs = '0; req_rt = '0; req_imm = '0;
        m_ptr = 0; m_cnt = 0; m_full = 0; m_err = 0;
        #12;
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_count", 32'(word_count), 0);
        chk("rst_full", 32'(full), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_ready", 32'(req_ready), 1);
        @(negedge clk); rst = 1'b0;

        // Directed encodings
        do_start(8'h10);
        do_req(OP_ADD, 5'd3, 5'd1, 5'd2, 32'd0);
        chk("dir_add", qd(0), 32'h0022_1820);
        chk("dir_add_addr", qa(0), 32'h10);
        do_req(OP_LI, 5'd0, 5'd0, 5'd8, 32'h1234_5678);
        chk("dir_li_lui", qd(0), 32'h3C08_1234);
        chk("dir_li_ori", qd(1), 32'h3508_5678);
        chk("dir_li_addr1", qa(1), 32'h12);
        do_req(OP_LI, 5'd0, 5'd0, 5'd8, 32'hFFFF_FFFB);
        chk("dir_li_neg", qd(0), 32'h2008_FFFB);
        do_req(OP_LI, 5'd0, 5'd0, 5'd8, 32'h0005_0000);
        chk("dir_li_upper", qd(0), 32'h3C08_0005);
        do_req(OP_SW, 5'd0, 5'd29, 5'd9, 32'd4);
        chk("dir_sw", qd(0), 32'hAFA9_0004);
        do_req(OP_J, 5'd0, 5'd0, 5'd0, 32'h40);
        chk("dir_j", qd(0), 32'h0800_0040);
        do_req(5'h1F, 5'd1, 5'd2, 5'd3, 32'd7);
        do_req(OP_MUL, 5'd4, 5'd5, 5'd6, 32'd0);
        do_req(OP_JALR, 5'd0, 5'd7, 5'd0, 32'd0);

        // Filling the last two slots
        do_start(8'hFE);
        do_req(OP_ADD, 5'd1, 5'd1, 5'd1, 32'd0);
        do_req(OP_ADD, 5'd2, 5'd2, 5'd2, 32'd0);
        do_req(OP_ADD, 5'd3, 5'd3, 5'd3, 32'd0);
        chk("full_ready", 32'(req_ready), 0);

        // Two-word LI with one slot left
        do_start(8'hFF);
        do_req(OP_LI, 5'd0, 5'd0, 5'd8, 32'h1234_5678);

        // start during EMIT1 aborts the ORI
        do_start(8'h40);
        accept_only(OP_LI, 5'd8, 32'h1234_5678);
        start = 1'b1; base_addr = 8'h40;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        chk("abort_writes", 32'(wq_data.size()), 1);
        chk("abort_mem_we", 32'(mem_we), 0);
        chk("abort_count", 32'(word_count), 0);
        m_ptr = 8'h40; m_cnt = 0; m_full = 0; m_err = 0;
        do_req(OP_OR, 5'd1, 5'd2, 5'd3, 32'd0);

        // rst during EMIT2
        do_start(8'h20);
        accept_only(OP_LI, 5'd9, 32'hABCD_0001);
        @(posedge clk); #1;
        chk("emit2_we", 32'(mem_we), 1);
        rst = 1'b1;
        #1;
        chk("rst2_mem_we", 32'(mem_we), 0);
        chk("rst2_mem_addr", 32'(mem_addr), 0);
        chk("rst2_mem_wdata", mem_wdata, 0);
        chk("rst2_count", 32'(word_count), 0);
        chk("rst2_full", 32'(full), 0);
        chk("rst2_err", 32'(err), 0);
        @(negedge clk); rst = 1'b0;
        m_ptr = 0; m_cnt = 0; m_full = 0; m_err = 0;
        do_req(OP_ADD, 5'd3, 5'd1, 5'd2, 32'd0);

        // Randomized requests against the model
        do_start(8'($urandom_range(200, 255)));
        for (int i = 0; i < 80; i++) begin
            if (m_full && $urandom_range(0, 1) == 1) do_start(8'($urandom_range(200, 255)));
            do_req(($urandom_range(0, 9) == 0) ? 5'h1F : 5'($urandom_range(0, 22)),
                   5'($urandom), 5'($urandom), 5'($urandom), rand_imm());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
